controller_cripto: RTL and testbench
====================================

// Module: controller_cripto
// PURPOSE
//   Iterative AES-128 encryption controller (FIPS-197). This is the encrypt-side
//   counterpart of the decryption controller: it maps palavra -> cifra under chave.
//   One round is computed per clock, and round keys are expanded on the fly.
//   The block sits between the I2C register interface and the cipher datapath.
// PARAMETERS
//   NUM_ROUNDS  10  AES-128 round count; only 10 is supported.
// PORTS
//   clk      in   1    single clock; all state updates on posedge clk.
//   rst      in   1    asynchronous, active-low reset (asserted when 0).
//   start    in   1    request; sampled only in IDLE.
//   palavra  in   128  plaintext; bits [127:120] are byte 0 (FIPS-197 order).
//   chave    in   128  cipher key, same byte order.
//   cifra    out  128  ciphertext register; holds value until next completion.
//   done     out  1    one-cycle pulse when cifra is updated.
//   busy     out  1    high while an encryption is in progress.
// BEHAVIOUR
// - Reset (rst=0, async):
//     state=IDLE, cifra=0, done=0, busy=0.
//     Internal state, key and rcon registers are cleared.
// - FSM states: IDLE, ROUND.
//   No separate load or finish states; one round per clock.
// - IDLE:
//     done=0, busy=0.
//     If start=1 at a posedge:
//       st <= palavra ^ chave; rk <= chave; rcon <= 8'h01; rnd <= 1; -> ROUND.
// - ROUND (busy=1). Each posedge:
//     nk = next round key from rk and rcon (on-the-fly key schedule:
//       RotWord, SubWord, ^rcon, then word chaining).
//     rnd 1..9:  st <= MixColumns(ShiftRows(SubBytes(st))) ^ nk.
//     rnd 10:    t = ShiftRows(SubBytes(st)) ^ nk (no MixColumns);
//                cifra <= t, done <= 1, busy <= 0 -> IDLE.
//     Each round also updates: rk <= nk; rnd <= rnd+1;
//       rcon <= xtime(rcon) (0x80 -> 0x1b).
// - Latency: start sampled at edge E0; done=1 and cifra valid in the cycle after
//   edge E10. That is 10 cycles from start acceptance to done.
// - done is high for exactly one cycle and is registered.
//   It falls at the next edge, when the FSM is back in IDLE.
// - busy rises in the cycle after start is accepted.
//   It is high for 10 cycles and falls together with the done assertion.
// - start while busy=1 is ignored (no queueing, no restart).
//   Level-held start re-triggers: it is sampled in IDLE on the cycle done=1,
//   so back-to-back operations run with no gap.
// - palavra and chave are captured at acceptance.
//   Changes during ROUND do not affect the result.
// - rst asserted mid-operation aborts the encryption immediately.
//   cifra is cleared to 0, no done pulse is produced, and the FSM returns to IDLE.
// - Implementation constraints:
//     Reuse the existing combinational sub_bytes, shift_rows, mix_columns and
//     add_round_key blocks.
//     Do not instantiate the full 1408-bit expansion_key.
//     All FSM outputs come from registers; there are no latches and no
//     combinational loops.
// TESTING
// - FIPS-197 C.1: chave=000102030405060708090a0b0c0d0e0f,
//   palavra=00112233445566778899aabbccddeeff
//     -> cifra=69c4e0d86a7b0430d8cdb78070b4c55a, done 10 cycles after start.
// - FIPS-197 App.B: chave=2b7e151628aed2a6abf7158809cf4f3c,
//   palavra=3243f6a8885a308d313198a2e0370734
//     -> cifra=3925841d02dc09fbdc118597196a0b32.
// - Pulse start during busy, and change palavra/chave at round 5
//     -> result is still the original vector's cifra; exactly one done pulse.
// - Assert rst=0 at round 4
//     -> cifra=0, done=0, busy=0 immediately.
//     After release, the C.1 vector completes correctly.
// - Hold start=1 continuously with the C.1 vector
//     -> done pulses every 11 cycles, and cifra equals 69c4e0d8... each time.
// - All-zero key and plaintext
//     -> cifra=66e94bd4ef8a2c3b884cfa59ca342b2e.

Source files
------------

// File: rtl/controller_cripto.sv
// Iterative AES-128 encryption controller: one round per clock,
// with the round key expanded on the fly.
module controller_cripto #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] palavra,
  input  logic [127:0] chave,
  output logic [127:0] cifra,
  output logic         done,
  output logic         busy
);

  typedef enum logic {S_IDLE, S_ROUND} state_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as a^254 (field inverse) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] r;
    s = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] a);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = sbox(a[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] a);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = a[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] a);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = a[127-32*c -: 8];
      a1 = a[119-32*c -: 8];
      a2 = a[111-32*c -: 8];
      a3 = a[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] a,
                                                 input logic [127:0] k);
    return a ^ k;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] rk,
                                            input logic [7:0]   rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]),
          sbox(w3[7:0]),   sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t       r_state, w_state_n;
  logic [127:0] r_st, w_st_n;
  logic [127:0] r_rk, w_rk_n;
  logic [7:0]   r_rcon, w_rcon_n;
  logic [3:0]   r_rnd, w_rnd_n;
  logic [127:0] r_cifra, w_cifra_n;
  logic         r_done, w_done_n;
  logic         r_busy, w_busy_n;

  logic [127:0] w_nk;
  logic [127:0] w_sr;
  logic [127:0] w_mid;
  logic [127:0] w_last;

  assign w_nk   = key_step(r_rk, r_rcon);
  assign w_sr   = shift_rows(sub_bytes(r_st));
  assign w_mid  = add_round_key(mix_columns(w_sr), w_nk);
  assign w_last = add_round_key(w_sr, w_nk);

  always_comb begin
    w_state_n = r_state;
    w_st_n    = r_st;
    w_rk_n    = r_rk;
    w_rcon_n  = r_rcon;
    w_rnd_n   = r_rnd;
    w_cifra_n = r_cifra;
    w_done_n  = 1'b0;
    w_busy_n  = r_busy;
    unique case (r_state)
      S_IDLE: begin
        w_busy_n = 1'b0;
        if (start) begin
          w_st_n    = add_round_key(palavra, chave);
          w_rk_n    = chave;
          w_rcon_n  = 8'h01;
          w_rnd_n   = 4'd1;
          w_busy_n  = 1'b1;
          w_state_n = S_ROUND;
        end
      end
      S_ROUND: begin
        w_rk_n   = w_nk;
        w_rcon_n = xt(r_rcon);
        w_rnd_n  = r_rnd + 4'd1;
        w_st_n   = w_mid;
        if (r_rnd == NUM_ROUNDS[3:0]) begin
          w_st_n    = w_last;
          w_cifra_n = w_last;
          w_done_n  = 1'b1;
          w_busy_n  = 1'b0;
          w_state_n = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_st    <= '0;
      r_rk    <= '0;
      r_rcon  <= '0;
      r_rnd   <= '0;
      r_cifra <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_st    <= w_st_n;
      r_rk    <= w_rk_n;
      r_rcon  <= w_rcon_n;
      r_rnd   <= w_rnd_n;
      r_cifra <= w_cifra_n;
      r_done  <= w_done_n;
      r_busy  <= w_busy_n;
    end
  end

  assign cifra = r_cifra;
  assign done  = r_done;
  assign busy  = r_busy;

endmodule

// File: tb/tb_controller_cripto.sv
// Bench for controller_cripto: FIPS-197 vectors plus random
// blocks against a table-driven AES-128 reference model.
module tb_controller_cripto;

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] palavra = '0;
  logic [127:0] chave = '0;
  logic [127:0] cifra;
  logic         done;
  logic         busy;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  logic [7:0] sbox_t [256];

  controller_cripto dut (
    .clk(clk), .rst(rst), .start(start),
    .palavra(palavra), .chave(chave),
    .cifra(cifra), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic int m_mul(input int a, input int b);
    int p = 0;
    int x = a;
    for (int i = 0; i < 8; i++) begin
      if (((b >> i) & 1) != 0) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
    end
    return p;
  endfunction

  function automatic void build_sbox();
    for (int a = 0; a < 256; a++) begin
      int inv = 0;
      int s = 0;
      for (int b = 1; b < 256; b++)
        if (m_mul(a, b) == 1) inv = b;
      for (int i = 0; i < 8; i++) begin
        int bit_v = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^
                     (inv >> ((i + 5) % 8)) ^ (inv >> ((i + 6) % 8)) ^
                     (inv >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
        s = s | (bit_v << i);
      end
      sbox_t[a] = 8'(s);
    end
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt,
                                           input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tw;
    logic [7:0]   rc = 8'h01;
    logic [127:0] o = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {sbox_t[tw[31:24]], sbox_t[tw[23:16]],
              sbox_t[tw[15:8]], sbox_t[tw[7:0]]} ^ {rc, 24'h0};
        rc = 8'(m_mul(int'(rc), 2));
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int i = 0; i < 16; i++)
      s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r+4*c] = sbox_t[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rd < 10)
            s[r+4*c] = 8'(m_mul(t[4*c+r], 2) ^ m_mul(t[4*c+(r+1)%4], 3)
                       ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4]);
          else
            s[r+4*c] = t[r+4*c];
        end
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic run_op(input logic [127:0] p, input logic [127:0] k,
                        input logic [127:0] exp, input string tag);
    int n = 0;
    palavra = p;
    chave = k;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 10);
    chk({tag, "_ct"}, cifra, exp);
    chk({tag, "_busy_end"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, "_done_fall"}, done, 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] p, k, got;
    int prev, pulses, n;
    build_sbox();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cifra", cifra, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    run_op(P_C1, K_C1, C_C1, "c1");
    run_op(P_B, K_B, C_B, "appb");
    run_op('0, '0, C_Z, "zero");
    for (int i = 0; i < 8; i++) begin
      p = rnd128();
      k = rnd128();
      run_op(p, k, aes_ref(p, k), $sformatf("rnd%0d", i));
    end

    // start pulse while busy and input changes mid-operation
    palavra = P_C1;
    chave = K_C1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0;
    got = '0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 3) start = 1'b1;
      if (cyc == 4) start = 1'b0;
      if (cyc == 5) begin
        palavra = rnd128();
        chave = rnd128();
      end
      if (done) got = cifra;
    end
    chk("busy_ct", got, C_C1);
    chk("busy_pulses", done_cnt, 1);
    chk("busy_idle", busy, 0);

    // abort by reset during round 4
    palavra = P_B;
    chave = K_B;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    done_cnt = 0;
    rst = 1'b0;
    #1;
    chk("abort_cifra", cifra, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_nodone", done_cnt, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    run_op(P_C1, K_C1, C_C1, "after_rst");

    // level-held start: back-to-back operations
    palavra = P_C1;
    chave = K_C1;
    start = 1'b1;
    prev = -1;
    pulses = 0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        chk("held_ct", cifra, C_C1);
        if (prev >= 0) chk("held_gap", cyc - prev, 11);
        else chk("held_first", cyc, 11);
        prev = cyc;
      end
    end
    chk("held_pulses", pulses, 4);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("held_tail_done", done, 1);
    chk("held_tail_ct", cifra, C_C1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
